// File: rtl/branch_ctrl.sv
// Flag register, branch resolver and PC sequencer: a branch is accepted in IDLE and resolved one cycle later in EVAL.
// br_ready drops for the single EVAL cycle after each accept, giving one branch every two cycles.
module branch_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_flag [3],
  input  logic            flag_we,
  input  logic            step,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_offset,
  output logic [2:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic            redirect
);

  typedef enum logic {IDLE, EVAL} state_t;

  typedef struct packed {
    logic [2:0]      cond;
    logic [PC_W-1:0] offset;
  } br_req_t;

  state_t          state_q, state_d;
  br_req_t         req_q;
  logic [2:0]      flags_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            redirect_q, redirect_d;
  logic            accept;
  logic            cond_hit;
  logic            flag_z, flag_n, flag_v;

  assign flag_z   = flags_q[0];
  assign flag_n   = flags_q[1];
  assign flag_v   = flags_q[2];

  assign br_ready = (state_q == IDLE) & ~reset;
  assign accept   = br_valid & br_ready;

  // N is the true sign of the widened ALU result, so LT/GE need no V correction.
  always_comb begin
    cond_hit = 1'b0;
    case (req_q.cond)
      3'b000:  cond_hit = 1'b1;
      3'b001:  cond_hit = flag_z;
      3'b010:  cond_hit = ~flag_z;
      3'b011:  cond_hit = flag_n;
      3'b100:  cond_hit = ~flag_n;
      3'b101:  cond_hit = ~flag_n & ~flag_z;
      3'b110:  cond_hit = flag_n | flag_z;
      3'b111:  cond_hit = flag_v;
      default: cond_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    taken_d    = taken_q;
    redirect_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EVAL;
        end else if (step) begin
          pc_d = pc_q + 1'b1;
        end
      end
      EVAL: begin
        // Offset is PC_W wide already, so modulo-2^PC_W addition is the sign extension.
        pc_d       = pc_q + 1'b1 + (cond_hit ? req_q.offset : '0);
        taken_d    = cond_hit;
        redirect_d = cond_hit;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      flags_q    <= 3'b000;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      if (flag_we) begin
        flags_q <= {alu_flag[2], alu_flag[1], alu_flag[0]};
      end
      if (accept) begin
        req_q.cond   <= br_cond;
        req_q.offset <= br_offset;
      end
    end
  end

  assign flags    = flags_q;
  assign pc       = pc_q;
  assign taken    = taken_q;
  assign redirect = redirect_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: flag capture, condition codes, PC wrap, step masking and reset during EVAL.
module tb_branch_ctrl;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_flag [3];
  logic            flag_we;
  logic            step;
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_offset;
  logic [2:0]      flags;
  logic [PC_W-1:0] pc;
  logic            taken;
  logic            redirect;

  int compared   = 0;
  int mismatched = 0;

  branch_ctrl #(.PC_W(PC_W), .RESET_PC(8'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_flag  (alu_flag),
    .flag_we   (flag_we),
    .step      (step),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_cond   (br_cond),
    .br_offset (br_offset),
    .flags     (flags),
    .pc        (pc),
    .taken     (taken),
    .redirect  (redirect)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic v, input logic n, input logic z);
    alu_flag[2] = v;
    alu_flag[1] = n;
    alu_flag[0] = z;
  endtask

  // Present a request for exactly the accept cycle, then drop it for EVAL.
  task automatic branch(input logic [2:0] cond, input logic [PC_W-1:0] off);
    br_valid  = 1'b1;
    br_cond   = cond;
    br_offset = off;
    tick();
    br_valid  = 1'b0;
    br_cond   = 3'b000;
    br_offset = '0;
  endtask

  initial begin
    reset = 1'b1; flag_we = 1'b0; step = 1'b0;
    br_valid = 1'b0; br_cond = 3'b000; br_offset = '0;
    set_flags(1'b0, 1'b0, 1'b0);
    #1;
    check("rdy_in_reset", {31'd0, br_ready}, 32'd0);
    ticks(2);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_flags", {29'd0, flags}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);

    // 1: sequential stepping, then reset again
    reset = 1'b0;
    #1;
    check("rdy_idle", {31'd0, br_ready}, 32'd1);
    step = 1'b1;
    ticks(5);
    step = 1'b0;
    check("step5_pc", {24'd0, pc}, 32'd5);
    set_flags(1'b1, 1'b1, 1'b1); flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
    check("flags_vnz", {29'd0, flags}, 32'd7);
    reset = 1'b1;
    tick();
    check("rst2_pc", {24'd0, pc}, 32'd0);
    check("rst2_flags", {29'd0, flags}, 32'd0);
    check("rst2_rdy", {31'd0, br_ready}, 32'd0);
    reset = 1'b0;

    // 2: flag write in the accept cycle is visible to BEQ
    step = 1'b1; ticks(10); step = 1'b0;
    check("pc10", {24'd0, pc}, 32'd10);
    set_flags(1'b0, 1'b0, 1'b1); flag_we = 1'b1;
    branch(3'b001, 8'd3);
    flag_we = 1'b0;
    check("beq_accept_pc", {24'd0, pc}, 32'd10);
    check("beq_accept_rdy", {31'd0, br_ready}, 32'd0);
    check("beq_accept_flags", {29'd0, flags}, 32'd1);
    tick();
    check("beq_pc", {24'd0, pc}, 32'd14);
    check("beq_taken", {31'd0, taken}, 32'd1);
    check("beq_redirect", {31'd0, redirect}, 32'd1);
    check("beq_rdy_back", {31'd0, br_ready}, 32'd1);
    tick();
    check("beq_redirect_drop", {31'd0, redirect}, 32'd0);
    check("beq_taken_hold", {31'd0, taken}, 32'd1);
    check("beq_pc_hold", {24'd0, pc}, 32'd14);

    // 3: N=1, Z=0: GE not taken, LT taken with negative offset; step masked
    set_flags(1'b0, 1'b1, 1'b0); flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
    check("flags_n", {29'd0, flags}, 32'd2);
    step = 1'b1; ticks(6); step = 1'b0;
    check("pc20", {24'd0, pc}, 32'd20);
    branch(3'b100, 8'hFC);
    tick();
    check("bge_pc", {24'd0, pc}, 32'd21);
    check("bge_taken", {31'd0, taken}, 32'd0);
    check("bge_redirect", {31'd0, redirect}, 32'd0);
    step = 1'b1;
    branch(3'b011, 8'hFC);
    check("blt_accept_pc", {24'd0, pc}, 32'd21);
    tick();
    step = 1'b0;
    check("blt_pc", {24'd0, pc}, 32'd18);
    check("blt_taken", {31'd0, taken}, 32'd1);
    check("blt_redirect", {31'd0, redirect}, 32'd1);

    // 4: wrap-around in both stepping and branching
    step = 1'b1; ticks(237); step = 1'b0;
    check("pc255", {24'd0, pc}, 32'd255);
    step = 1'b1; tick(); step = 1'b0;
    check("step_wrap", {24'd0, pc}, 32'd0);
    step = 1'b1; ticks(254); step = 1'b0;
    check("pc254", {24'd0, pc}, 32'd254);
    branch(3'b000, 8'd2);
    tick();
    check("always_wrap_pc", {24'd0, pc}, 32'd1);
    check("always_taken", {31'd0, taken}, 32'd1);

    // 5: flag write during EVAL is not seen by BNE (old Z=0)
    branch(3'b010, 8'd5);
    set_flags(1'b0, 1'b0, 1'b1); flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
    check("bne_pc", {24'd0, pc}, 32'd7);
    check("bne_taken", {31'd0, taken}, 32'd1);
    check("bne_flags_after", {29'd0, flags}, 32'd1);

    // Overflow and LE/GT with V only
    set_flags(1'b1, 1'b0, 1'b0); flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
    branch(3'b111, 8'd3);
    tick();
    check("bov_pc", {24'd0, pc}, 32'd11);
    branch(3'b110, 8'd3);
    tick();
    check("ble_pc", {24'd0, pc}, 32'd12);
    check("ble_taken", {31'd0, taken}, 32'd0);
    branch(3'b101, 8'hF8);
    tick();
    check("bgt_pc", {24'd0, pc}, 32'd5);
    check("bgt_taken", {31'd0, taken}, 32'd1);

    // 6: reset in EVAL discards the branch; next request accepted normally
    step = 1'b1; ticks(7); step = 1'b0;
    check("pc12", {24'd0, pc}, 32'd12);
    branch(3'b000, 8'd10);
    reset = 1'b1;
    tick();
    check("rst_eval_pc", {24'd0, pc}, 32'd0);
    check("rst_eval_taken", {31'd0, taken}, 32'd0);
    check("rst_eval_redirect", {31'd0, redirect}, 32'd0);
    check("rst_eval_rdy", {31'd0, br_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_rdy", {31'd0, br_ready}, 32'd1);
    branch(3'b000, 8'd4);
    tick();
    check("post_rst_pc", {24'd0, pc}, 32'd5);
    check("post_rst_taken", {31'd0, taken}, 32'd1);
    check("post_rst_redirect", {31'd0, redirect}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
